mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BITSIZE, default 32: bits per word.
REQ-002 SHALL have parameter N_WORDS_PER_ADDR, default 4: words per memory line; LINE = N_WORDS_PER_ADDR*BITSIZE.
REQ-003 SHALL have parameter N_ACCESSORS, default 4 (legal range 1..16): number of requesting ports.
REQ-004 SHALL have parameter ARB_MODE, default 0: 0 = fixed priority, 1 = round-robin.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255: abort after this many unacknowledged access cycles; 0 disables the timeout.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port acc_address_i, input, 32*N_ACCESSORS bits: per-accessor address, slice i = [32i+31:32i].
REQ-009 SHALL have port acc_store_i, input, N_ACCESSORS bits: per-accessor store request.
REQ-010 SHALL have port acc_load_i, input, N_ACCESSORS bits: per-accessor load request.
REQ-011 SHALL have port acc_data_i, input, LINE*N_ACCESSORS bits: per-accessor store data, slice i.
REQ-012 SHALL have port acc_data_o, output, LINE*N_ACCESSORS bits: per-accessor registered load data, slice i.
REQ-013 SHALL have port acc_done_o, output, N_ACCESSORS bits: one-cycle completion pulse.
REQ-014 SHALL have port acc_err_o, output, N_ACCESSORS bits: one-cycle timeout flag, coincident with done.
REQ-015 SHALL have port mem_addr_o, output, 32 bits: memory address.
REQ-016 SHALL have port mem_data_o, output, LINE bits: memory write data.
REQ-017 SHALL have port mem_store_o, output, 1 bit: 1 = write, 0 = read.
REQ-018 SHALL have port mem_valid_o, output, 1 bit: request valid.
REQ-019 SHALL have port mem_data_i, input, LINE bits: memory read data.
REQ-020 SHALL have port mem_valid_i, input, 1 bit: memory acknowledge.

Function
REQ-021 SHALL implement the states IDLE, BUSY and DONE, all registered; there SHALL be no combinational path from acc_* inputs to any mem_* output.
REQ-022 In IDLE, a requester is any i with acc_store_i[i] or acc_load_i[i] set; if both are set for the same i, that request is a store.
REQ-023 In fixed mode the winner SHALL be the lowest requesting index; in round-robin mode it SHALL be the first requester found scanning upward from last_grant+1, wrapping modulo N_ACCESSORS.
REQ-024 On a grant the block SHALL latch the winner index, its address, its store data and the store/load type, update last_grant to the winner, clear the timeout counter and go to BUSY; with no requesters it SHALL stay in IDLE.
REQ-025 In BUSY, mem_valid_o SHALL be 1 and mem_addr_o, mem_data_o and mem_store_o SHALL be driven only from the latched registers, held stable until the acknowledge.
REQ-026 The acknowledge cycle is the BUSY cycle with mem_valid_i=1: for a load, capture mem_data_i into acc_data_o slice[winner]; for either type, go to DONE with err=0.
REQ-027 In BUSY without mem_valid_i the counter SHALL increment; when TIMEOUT_CYCLES is nonzero and the counter reaches TIMEOUT_CYCLES-1, the block SHALL go to DONE with err=1 and leave acc_data_o unchanged.
REQ-028 Requests withdrawn or changed during BUSY SHALL be ignored; the latched transaction always completes or times out.
REQ-029 In DONE, acc_done_o[winner]=1 and acc_err_o[winner]=err for exactly one cycle, all other bits 0, mem_valid_o=0; the next state SHALL be IDLE.
REQ-030 Latency: request sampled in IDLE at cycle T; mem_valid_o=1 from T+1; acknowledge at T+k gives done at T+k+1. The minimum period between grants is 3 cycles.
REQ-031 acc_data_o slice i SHALL hold its value until the next successful load by accessor i; stores SHALL NOT modify acc_data_o.
REQ-032 mem_valid_i asserted outside BUSY SHALL be ignored.
REQ-033 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide (minimum 1) and SHALL NOT wrap.

Reset
REQ-034 While reset_i=1 at a clock edge: state=IDLE, last_grant=N_ACCESSORS-1 (accessor 0 wins first), counter=0, all acc_data_o/acc_done_o/acc_err_o=0, mem_valid_o=0, mem_store_o=0, mem_addr_o=0, mem_data_o=0.
REQ-035 Reset asserted in BUSY or DONE SHALL abort the transaction with no done pulse and no acc_data_o update.

Verification
REQ-036 Fixed mode, N=4, loads on 1 and 3 together, memory acks 2 cycles after valid -> accessor 1 served first, then 3; acc_data_o slices 1 and 3 hold the respective mem_data_i values.
REQ-037 RR mode, all 4 requesting loads continuously after reset -> grant order 0,1,2,3,0; each done pulse is exactly 1 cycle and grants are 3 cycles apart with immediate acks.
REQ-038 Accessor 2 asserts store and load together with addr 0x100 and data 0xA5.. -> mem_store_o=1, mem_addr_o=0x100, mem_data_o=0xA5.., and acc_data_o[2] is unchanged.
REQ-039 TIMEOUT_CYCLES=4, no mem_valid_i -> mem_valid_o high for 4 cycles, then acc_done_o and acc_err_o of the winner pulse together.
REQ-040 reset_i pulsed in the middle of BUSY -> the next cycle is IDLE, mem_valid_o=0, no done, and the RR pointer restarts at 0.
REQ-041 Requester drops its request and changes its address during BUSY -> the memory still sees the original address and done still pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port among N_ACCESSORS requesters.
// A transaction goes IDLE -> BUSY -> DONE -> IDLE. In IDLE one requester is
// granted, either the lowest index (ARB_MODE=0) or round-robin after the last
// grant (ARB_MODE=1). Its address, data and type are latched and presented
// to memory until mem_valid_i arrives or the optional timeout expires.
//
// Ports:
//   clk, reset_i                - clock, synchronous active-high reset
//   acc_address_i[32*N]         - per-accessor address, slice i = [32i +: 32]
//   acc_store_i/acc_load_i[N]   - per-accessor request (store wins if both set)
//   acc_data_i[LINE*N]          - per-accessor store data
//   acc_data_o[LINE*N]          - per-accessor registered load data
//   acc_done_o/acc_err_o[N]     - one-cycle completion / timeout pulse
//   mem_addr_o, mem_data_o      - latched memory address / write data
//   mem_store_o, mem_valid_o    - write strobe type and request valid
//   mem_data_i, mem_valid_i     - memory read data and acknowledge
module mem_arbiter #(
    parameter int BITSIZE          = 32,
    parameter int N_WORDS_PER_ADDR = 4,
    parameter int N_ACCESSORS      = 4,
    parameter int ARB_MODE         = 0,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                                            clk,
    input  logic                                            reset_i,
    input  logic [32*N_ACCESSORS-1:0]                       acc_address_i,
    input  logic [N_ACCESSORS-1:0]                          acc_store_i,
    input  logic [N_ACCESSORS-1:0]                          acc_load_i,
    input  logic [N_WORDS_PER_ADDR*BITSIZE*N_ACCESSORS-1:0] acc_data_i,
    output logic [N_WORDS_PER_ADDR*BITSIZE*N_ACCESSORS-1:0] acc_data_o,
    output logic [N_ACCESSORS-1:0]                          acc_done_o,
    output logic [N_ACCESSORS-1:0]                          acc_err_o,
    output logic [31:0]                                     mem_addr_o,
    output logic [N_WORDS_PER_ADDR*BITSIZE-1:0]             mem_data_o,
    output logic                                            mem_store_o,
    output logic                                            mem_valid_o,
    input  logic [N_WORDS_PER_ADDR*BITSIZE-1:0]             mem_data_i,
    input  logic                                            mem_valid_i
);

    localparam int LINE  = N_WORDS_PER_ADDR * BITSIZE;
    localparam int IDX_W = (N_ACCESSORS > 1) ? $clog2(N_ACCESSORS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   win_q, last_q;
    logic [31:0]        addr_q;
    logic [LINE-1:0]    wdata_q;
    logic               store_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [N_ACCESSORS-1:0] req;
    logic                   grant_vld;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       scan_idx;
    logic                   timeout_hit;

    // Arbitration: scan all accessors starting at the mode's base index,
    // first requester found wins.
    always_comb begin
        req       = acc_store_i | acc_load_i;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_ACCESSORS; k++) begin
            if (ARB_MODE == 1)
                scan_idx = IDX_W'((int'(last_q) + 1 + k) % N_ACCESSORS);
            else
                scan_idx = IDX_W'(k);
            if (!grant_vld && req[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic; an acknowledge in the last allowed cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_vld) state_d = BUSY;
            BUSY: if (mem_valid_i || timeout_hit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q    <= IDLE;
            win_q      <= '0;
            last_q     <= IDX_W'(N_ACCESSORS - 1);
            addr_q     <= '0;
            wdata_q    <= '0;
            store_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            acc_data_o <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        win_q   <= grant_idx;
                        last_q  <= grant_idx;
                        addr_q  <= acc_address_i[int'(grant_idx)*32 +: 32];
                        wdata_q <= acc_data_i[int'(grant_idx)*LINE +: LINE];
                        store_q <= acc_store_i[grant_idx];
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (mem_valid_i) begin
                        err_q <= 1'b0;
                        if (!store_q)
                            acc_data_o[int'(win_q)*LINE +: LINE] <= mem_data_i;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        // saturate rather than wrap when the timeout is disabled
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion pulses decode straight from registered state.
    always_comb begin
        acc_done_o = '0;
        acc_err_o  = '0;
        if (state_q == DONE) begin
            acc_done_o[win_q] = 1'b1;
            acc_err_o[win_q]  = err_q;
        end
    end

    assign mem_valid_o = (state_q == BUSY);
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = wdata_q;
    assign mem_store_o = store_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Two instances (fixed priority and
// round-robin, both with a 4-cycle timeout) share all inputs except reset;
// the idle one is held in reset while the other is exercised.
module tb_mem_arbiter;

    localparam int N    = 4;
    localparam int LINE = 32;
    localparam int TO   = 4;

    logic                clk = 1'b0;
    logic                rst_f, rst_r;
    logic [32*N-1:0]     acc_address_i;
    logic [N-1:0]        acc_store_i, acc_load_i;
    logic [LINE*N-1:0]   acc_data_i;
    logic [LINE-1:0]     mem_data_i;
    logic                mem_valid_i;

    logic [LINE*N-1:0]   f_data_o, r_data_o, o_data;
    logic [N-1:0]        f_done, r_done, o_done, f_err, r_err, o_err;
    logic [31:0]         f_addr, r_addr, o_addr;
    logic [LINE-1:0]     f_wdata, r_wdata, o_wdata;
    logic                f_store, r_store, o_store, f_valid, r_valid, o_valid;

    logic                sel;   // 1 = observe fixed-priority instance
    int                  n_chk = 0, n_fail = 0;
    logic [LINE-1:0]     m_data [N];
    int                  m_last;

    always #5 clk = ~clk;

    mem_arbiter #(.BITSIZE(8), .N_WORDS_PER_ADDR(4), .N_ACCESSORS(N),
                  .ARB_MODE(0), .TIMEOUT_CYCLES(TO)) u_fix (
        .clk(clk), .reset_i(rst_f), .acc_address_i(acc_address_i),
        .acc_store_i(acc_store_i), .acc_load_i(acc_load_i), .acc_data_i(acc_data_i),
        .acc_data_o(f_data_o), .acc_done_o(f_done), .acc_err_o(f_err),
        .mem_addr_o(f_addr), .mem_data_o(f_wdata), .mem_store_o(f_store),
        .mem_valid_o(f_valid), .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i));

    mem_arbiter #(.BITSIZE(8), .N_WORDS_PER_ADDR(4), .N_ACCESSORS(N),
                  .ARB_MODE(1), .TIMEOUT_CYCLES(TO)) u_rr (
        .clk(clk), .reset_i(rst_r), .acc_address_i(acc_address_i),
        .acc_store_i(acc_store_i), .acc_load_i(acc_load_i), .acc_data_i(acc_data_i),
        .acc_data_o(r_data_o), .acc_done_o(r_done), .acc_err_o(r_err),
        .mem_addr_o(r_addr), .mem_data_o(r_wdata), .mem_store_o(r_store),
        .mem_valid_o(r_valid), .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i));

    always_comb begin
        o_data  = sel ? f_data_o : r_data_o;
        o_done  = sel ? f_done   : r_done;
        o_err   = sel ? f_err    : r_err;
        o_addr  = sel ? f_addr   : r_addr;
        o_wdata = sel ? f_wdata  : r_wdata;
        o_store = sel ? f_store  : r_store;
        o_valid = sel ? f_valid  : r_valid;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration rule: scan upward from the base index, first requester wins.
    function automatic int pick(input logic [N-1:0] req, input int last, input bit fixed);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = fixed ? k : (last + 1 + k) % N;
            if (req[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic check_data(input string tag);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s acc_data[%0d]", tag, i), 64'(o_data[i*LINE +: LINE]), 64'(m_data[i]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_data[i] = '0;
        m_last = N - 1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " valid"}, 64'(o_valid), 64'd0);
        chk({tag, " addr"},  64'(o_addr),  64'd0);
        chk({tag, " wdata"}, 64'(o_wdata), 64'd0);
        chk({tag, " store"}, 64'(o_store), 64'd0);
        chk({tag, " done"},  64'(o_done),  64'd0);
        chk({tag, " err"},   64'(o_err),   64'd0);
        check_data(tag);
    endtask

    // One transaction: drive requests while idle, follow the granted one
    // through memory, expect completion. ack_at = BUSY cycle carrying the
    // acknowledge (beyond TO means no acknowledge -> timeout).
    task automatic run_txn(input logic [N-1:0] st, input logic [N-1:0] ld, input int ack_at,
                           input int fidx, input logic [31:0] faddr, input logic [LINE-1:0] fdata);
        int w;
        logic [31:0]     ea;
        logic [LINE-1:0] ed, rd;
        bit              es, acked;
        for (int i = 0; i < N; i++) begin
            acc_address_i[i*32 +: 32]   = $urandom;
            acc_data_i[i*LINE +: LINE]  = $urandom;
        end
        if (fidx >= 0) begin
            acc_address_i[fidx*32 +: 32]  = faddr;
            acc_data_i[fidx*LINE +: LINE] = fdata;
        end
        acc_store_i = st;
        acc_load_i  = ld;
        mem_valid_i = 1'b0;
        w = pick(st | ld, m_last, sel);
        if (w < 0) begin
            tick();
            chk("no_req valid", 64'(o_valid), 64'd0);
            chk("no_req done", 64'(o_done), 64'd0);
            return;
        end
        ea = acc_address_i[w*32 +: 32];
        ed = acc_data_i[w*LINE +: LINE];
        es = st[w];
        tick();
        // winner withdraws and every address changes; latched values must hold
        acc_store_i[w] = 1'b0;
        acc_load_i[w]  = 1'b0;
        for (int i = 0; i < N; i++) acc_address_i[i*32 +: 32] = $urandom;
        m_last = w;
        acked  = 1'b0;
        rd     = '0;
        for (int c = 1; c <= 64; c++) begin
            chk("busy valid", 64'(o_valid), 64'd1);
            chk("busy addr",  64'(o_addr),  64'(ea));
            chk("busy store", 64'(o_store), 64'(es));
            if (es) chk("busy wdata", 64'(o_wdata), 64'(ed));
            chk("busy done", 64'(o_done), 64'd0);
            if (c == ack_at) begin
                rd          = $urandom;
                mem_data_i  = rd;
                mem_valid_i = 1'b1;
                tick();
                mem_valid_i = 1'b0;
                acked       = 1'b1;
                break;
            end
            if (c == TO) begin
                tick();
                break;
            end
            tick();
        end
        if (acked && !es) m_data[w] = rd;
        chk("done",       64'(o_done),  64'd1 << w);
        chk("err",        acked ? 64'd0 : 64'd1 << w, 64'(o_err));
        chk("done valid", 64'(o_valid), 64'd0);
        check_data("done");
        // acknowledge outside BUSY must be ignored
        mem_valid_i = 1'($urandom % 2);
        mem_data_i  = $urandom;
        tick();
        mem_valid_i = 1'b0;
        chk("idle done",  64'(o_done),  64'd0);
        chk("idle valid", 64'(o_valid), 64'd0);
        check_data("idle");
    endtask

    initial begin
        int w;
        sel = 1'b1; rst_f = 1'b1; rst_r = 1'b1;
        acc_address_i = '0; acc_store_i = '0; acc_load_i = '0;
        acc_data_i = '0; mem_data_i = '0; mem_valid_i = 1'b0;
        model_reset();
        tick(); tick();
        check_reset_state("fix reset");

        // fixed priority: loads from 1 and 3, ack two cycles after valid
        rst_f = 1'b0;
        run_txn(4'b0000, 4'b1010, 3, -1, 32'd0, '0);
        chk("fix order first", 64'(m_last), 64'd1);
        run_txn(4'b0000, 4'b1000, 3, -1, 32'd0, '0);
        chk("fix order second", 64'(m_last), 64'd3);
        for (int t = 0; t < 8; t++)
            run_txn(4'($urandom), 4'($urandom), $urandom_range(1, 5), -1, 32'd0, '0);

        // round-robin instance
        rst_f = 1'b1; sel = 1'b0;
        model_reset();
        tick();
        check_reset_state("rr reset");
        rst_r = 1'b0;

        // all four loading continuously with immediate acks
        for (int i = 0; i < N; i++) acc_address_i[i*32 +: 32] = $urandom;
        acc_load_i = 4'hF; mem_valid_i = 1'b1;
        w = 0;
        for (int j = 0; j < 15; j++) begin
            tick();
            case (j % 3)
                0: begin
                    w = pick(4'hF, m_last, 1'b0);
                    chk("stream grant order", 64'(w), 64'((j / 3) % N));
                    chk("stream valid", 64'(o_valid), 64'd1);
                    chk("stream addr", 64'(o_addr), 64'(acc_address_i[w*32 +: 32]));
                    mem_data_i = $urandom;
                    m_data[w]  = mem_data_i;
                    m_last     = w;
                end
                1: begin
                    chk("stream done", 64'(o_done), 64'd1 << w);
                    chk("stream err", 64'(o_err), 64'd0);
                    chk("stream done valid", 64'(o_valid), 64'd0);
                    mem_data_i = $urandom;
                end
                default: begin
                    chk("stream done width", 64'(o_done), 64'd0);
                    chk("stream idle valid", 64'(o_valid), 64'd0);
                    check_data("stream");
                end
            endcase
        end
        acc_load_i = '0; mem_valid_i = 1'b0;
        tick();

        // store+load from accessor 2: treated as store, load data untouched
        run_txn(4'b0100, 4'b0100, 2, 2, 32'h100, 32'hA5A5A5A5);
        // timeout: no acknowledge at all
        run_txn(4'b0000, 4'b0010, 99, -1, 32'd0, '0);
        // acknowledge in the very cycle the timeout would fire
        run_txn(4'b0001, 4'b0000, TO, -1, 32'd0, '0);

        // reset pulse in the middle of BUSY
        for (int i = 0; i < N; i++) acc_address_i[i*32 +: 32] = $urandom;
        acc_load_i = 4'b0110;
        tick();
        chk("mid-reset busy", 64'(o_valid), 64'd1);
        acc_load_i = '0;
        tick();
        rst_r = 1'b1;
        tick();
        rst_r = 1'b0;
        model_reset();
        chk("mid-reset valid", 64'(o_valid), 64'd0);
        chk("mid-reset done", 64'(o_done), 64'd0);
        check_data("mid-reset");
        tick();
        chk("mid-reset no done", 64'(o_done), 64'd0);
        chk("mid-reset idle valid", 64'(o_valid), 64'd0);
        run_txn(4'b0000, 4'hF, 1, -1, 32'd0, '0);
        chk("rr restart at 0", 64'(m_last), 64'd0);

        // randomized traffic
        run_txn(4'b0000, 4'b0000, 1, -1, 32'd0, '0);
        for (int t = 0; t < 40; t++)
            run_txn(4'($urandom), 4'($urandom), $urandom_range(1, 5), -1, 32'd0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
